// File: rtl/cpu_axi_pkg.sv
// ----------------------------------------------------------------------------
// cpu_axi_pkg
// Shared types and constants for the 8088 bus front-end AXI4-Lite master.
// Contents:
//   state_t        - FSM state encoding (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP)
//   RESP_OKAY      - AXI OKAY response code
//   ERR_READ_BYTE  - byte returned to the CPU when a read fails
//   TIMER_WIDTH    - width of the stall timeout counter
//   lane_select()  - extracts one byte lane from a 32-bit word
// ----------------------------------------------------------------------------
package cpu_axi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t RD_ADDR = 3'd1;
    localparam state_t RD_DATA = 3'd2;
    localparam state_t WR_REQ  = 3'd3;
    localparam state_t WR_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [7:0] ERR_READ_BYTE = 8'hFF;

    localparam int unsigned TIMER_WIDTH = 16;

    function automatic logic [7:0] lane_select(input logic [31:0] word,
                                               input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpu_axi_lite_master.sv
// ----------------------------------------------------------------------------
// cpu_axi_lite_master
// Turns the single-cycle fetch pulses of the 8088 bus capture logic into one
// AXI4-Lite read or write per CPU bus cycle. Returns the addressed byte and a
// busy flag for the CPU READY line, plus sticky debug error bits.
// Ports:
//   AXI_CLK, RESETN      clock, synchronous active-low reset
//   A, D, wstrb          CPU byte address, lane-placed write data, byte strobes
//   rdaddr_fetch         pulse: start a read
//   wraddr_fetch         pulse: write address valid
//   wrdata_fetch         pulse: write data valid
//   err_clear            clears err_resp and err_timeout
//   axi_busy             access in flight (combinational, includes pulses)
//   read_data            byte from the last read (8'hFF on error response)
//   err_resp             sticky: bad RRESP/BRESP or dropped duplicate pulse
//   err_timeout          sticky: a state was held for TIMEOUT_CYCLES cycles
//   AXI_*                AXI4-Lite master read and write channels
// ----------------------------------------------------------------------------
module cpu_axi_lite_master
    import cpu_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  AXI_CLK,
    input  logic                  RESETN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [31:0]           D,
    input  logic [3:0]            wstrb,
    input  logic                  rdaddr_fetch,
    input  logic                  wraddr_fetch,
    input  logic                  wrdata_fetch,
    input  logic                  err_clear,
    output logic                  axi_busy,
    output logic [7:0]            read_data,
    output logic                  err_resp,
    output logic                  err_timeout,
    output logic [ADDR_WIDTH-1:0] AXI_araddr,
    output logic                  AXI_arvalid,
    input  logic                  AXI_arready,
    input  logic [31:0]           AXI_rdata,
    input  logic [1:0]            AXI_rresp,
    input  logic                  AXI_rvalid,
    output logic                  AXI_rready,
    output logic [ADDR_WIDTH-1:0] AXI_awaddr,
    output logic                  AXI_awvalid,
    input  logic                  AXI_awready,
    output logic [31:0]           AXI_wdata,
    output logic [3:0]            AXI_wstrb,
    output logic                  AXI_wvalid,
    input  logic                  AXI_wready,
    input  logic [1:0]            AXI_bresp,
    input  logic                  AXI_bvalid,
    output logic                  AXI_bready
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [1:0]              lane_q, lane_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;

    // One-deep holding registers for pulses that cannot start right away.
    logic                    pend_r_q, pend_r_d;
    logic [ADDR_WIDTH-1:0]   pend_raddr_q, pend_raddr_d;
    logic                    pend_a_q, pend_a_d;
    logic [ADDR_WIDTH-1:0]   pend_waddr_q, pend_waddr_d;
    logic                    pend_d_q, pend_d_d;
    logic [31:0]             pend_wdata_q, pend_wdata_d;
    logic [3:0]              pend_wstrb_q, pend_wstrb_d;

    logic [7:0]              read_data_q, read_data_d;
    logic                    err_resp_q, err_resp_d;
    logic                    err_timeout_q, err_timeout_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;

    logic                    idle;
    logic                    start_rd, start_wr;
    logic                    resp_err, timeout_hit;
    logic                    aw_done, w_done;
    logic [ADDR_WIDTH-1:0]   a_aligned;
    logic [ADDR_WIDTH-1:0]   rd_src, wa_src;
    logic [31:0]             wd_src;
    logic [3:0]              ws_src;

    assign idle      = (state_q == IDLE);
    assign a_aligned = {A[ADDR_WIDTH-1:2], 2'b00};

    // A queued request is older than a same-cycle pulse, so it goes first.
    assign rd_src = pend_r_q ? pend_raddr_q : A;
    assign wa_src = pend_a_q ? pend_waddr_q : a_aligned;
    assign wd_src = pend_d_q ? pend_wdata_q : D;
    assign ws_src = pend_d_q ? pend_wstrb_q : wstrb;

    // Reads win over a complete write request arriving in the same cycle.
    assign start_rd = idle & (rdaddr_fetch | pend_r_q);
    assign start_wr = idle & ~(rdaddr_fetch | pend_r_q)
                    & (wraddr_fetch | pend_a_q) & (wrdata_fetch | pend_d_q);

    assign axi_busy = ~idle | rdaddr_fetch | wraddr_fetch | wrdata_fetch
                    | pend_r_q | pend_a_q | pend_d_q;

    assign aw_done = ~awvalid_q | AXI_awready;
    assign w_done  = ~wvalid_q | AXI_wready;

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        lane_d        = lane_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        pend_r_d      = pend_r_q;
        pend_raddr_d  = pend_raddr_q;
        pend_a_d      = pend_a_q;
        pend_waddr_d  = pend_waddr_q;
        pend_d_d      = pend_d_q;
        pend_wdata_d  = pend_wdata_q;
        pend_wstrb_d  = pend_wstrb_q;
        read_data_d   = read_data_q;
        resp_err      = 1'b0;

        // Pending-flag bookkeeping; a pulse hitting a full slot is dropped.
        if (start_rd) begin
            pend_r_d = pend_r_q & rdaddr_fetch;
            if (pend_r_q & rdaddr_fetch) pend_raddr_d = A;
        end else if (rdaddr_fetch) begin
            if (pend_r_q) begin
                resp_err = 1'b1;
            end else begin
                pend_r_d     = 1'b1;
                pend_raddr_d = A;
            end
        end

        if (start_wr) begin
            pend_a_d = pend_a_q & wraddr_fetch;
            if (pend_a_q & wraddr_fetch) pend_waddr_d = a_aligned;
        end else if (wraddr_fetch) begin
            if (pend_a_q) begin
                resp_err = 1'b1;
            end else begin
                pend_a_d     = 1'b1;
                pend_waddr_d = a_aligned;
            end
        end

        if (start_wr) begin
            pend_d_d = pend_d_q & wrdata_fetch;
            if (pend_d_q & wrdata_fetch) begin
                pend_wdata_d = D;
                pend_wstrb_d = wstrb;
            end
        end else if (wrdata_fetch) begin
            if (pend_d_q) begin
                resp_err = 1'b1;
            end else begin
                pend_d_d     = 1'b1;
                pend_wdata_d = D;
                pend_wstrb_d = wstrb;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_rd) begin
                    state_d   = RD_ADDR;
                    araddr_d  = {rd_src[ADDR_WIDTH-1:2], 2'b00};
                    lane_d    = rd_src[1:0];
                    arvalid_d = 1'b1;
                end else if (start_wr) begin
                    state_d   = WR_REQ;
                    awaddr_d  = wa_src;
                    wdata_d   = wd_src;
                    wstrb_d   = ws_src;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            RD_ADDR: begin
                if (AXI_arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (AXI_rvalid) begin
                    state_d  = IDLE;
                    rready_d = 1'b0;
                    if (AXI_rresp != RESP_OKAY) begin
                        read_data_d = ERR_READ_BYTE;
                        resp_err    = 1'b1;
                    end else begin
                        read_data_d = lane_select(AXI_rdata, lane_q);
                    end
                end
            end
            WR_REQ: begin
                // Address and data channels complete independently.
                if (AXI_awready) awvalid_d = 1'b0;
                if (AXI_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (AXI_bvalid) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    if (AXI_bresp != RESP_OKAY) resp_err = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    // Stall timer counts cycles spent in the current non-IDLE state. The
    // access is never aborted; valid must stay up until the handshake.
    always_comb begin
        timer_d = timer_q;
        if (idle || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign timeout_hit = ~idle & (timer_q == TIMEOUT_LAST);

    // A new error in the same cycle as err_clear wins.
    assign err_resp_d    = (err_resp_q & ~err_clear) | resp_err;
    assign err_timeout_d = (err_timeout_q & ~err_clear) | timeout_hit;

    always_ff @(posedge AXI_CLK) begin
        if (!RESETN) begin
            state_q       <= IDLE;
            araddr_q      <= '0;
            lane_q        <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            pend_r_q      <= 1'b0;
            pend_raddr_q  <= '0;
            pend_a_q      <= 1'b0;
            pend_waddr_q  <= '0;
            pend_d_q      <= 1'b0;
            pend_wdata_q  <= '0;
            pend_wstrb_q  <= '0;
            read_data_q   <= 8'h00;
            err_resp_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            lane_q        <= lane_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            pend_r_q      <= pend_r_d;
            pend_raddr_q  <= pend_raddr_d;
            pend_a_q      <= pend_a_d;
            pend_waddr_q  <= pend_waddr_d;
            pend_d_q      <= pend_d_d;
            pend_wdata_q  <= pend_wdata_d;
            pend_wstrb_q  <= pend_wstrb_d;
            read_data_q   <= read_data_d;
            err_resp_q    <= err_resp_d;
            err_timeout_q <= err_timeout_d;
            timer_q       <= timer_d;
        end
    end

    assign AXI_araddr  = araddr_q;
    assign AXI_arvalid = arvalid_q;
    assign AXI_rready  = rready_q;
    assign AXI_awaddr  = awaddr_q;
    assign AXI_wdata   = wdata_q;
    assign AXI_wstrb   = wstrb_q;
    assign AXI_awvalid = awvalid_q;
    assign AXI_wvalid  = wvalid_q;
    assign AXI_bready  = bready_q;
    assign read_data   = read_data_q;
    assign err_resp    = err_resp_q;
    assign err_timeout = err_timeout_q;

endmodule
